// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, control-FSM states and datapath mux selects.
// Used by the multi-cycle controller, the datapath and mainCtr.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Multi-cycle controller states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_R_WB   = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_LD_WB  = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that own the unified memory port and may stall on mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_op_class.sv
// Opcode classifier: turns the 6-bit primary opcode into one-hot-ish
// instruction class flags consumed by the DECODE state.
module mc_op_class
    import mips_pkg::*;
(
    input  logic [5:0] i_op_code,
    output logic       o_is_r,
    output logic       o_is_mem,
    output logic       o_is_load,
    output logic       o_is_beq,
    output logic       o_is_j,
    output logic       o_is_bad
);

    // Classify the opcode; anything unrecognised is flagged as bad
    always_comb begin
        o_is_r    = 1'b0;
        o_is_mem  = 1'b0;
        o_is_load = 1'b0;
        o_is_beq  = 1'b0;
        o_is_j    = 1'b0;
        o_is_bad  = 1'b0;
        case (i_op_code)
            OP_RTYPE: o_is_r   = 1'b1;
            OP_LW: begin
                o_is_mem  = 1'b1;
                o_is_load = 1'b1;
            end
            OP_SW:    o_is_mem = 1'b1;
            OP_BEQ:   o_is_beq = 1'b1;
            OP_J:     o_is_j   = 1'b1;
            default:  o_is_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control sequencer. A two-process FSM steps each
// instruction through fetch/decode/execute/memory/write-back, stalling in
// the memory states until mem_ready and abandoning an access that waits
// longer than WAIT_MAX cycles (0 disables the timeout).
module multi_cycle_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       i_or_d,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       reg_wr,
    output logic       m2r,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    // Counter wide enough to hold WAIT_MAX (at least one bit)
    localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WCNT_SAT   = {WCNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_next;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_is_load;
    logic              r_illegal;
    logic              r_timeout;

    logic w_is_r;
    logic w_is_mem;
    logic w_is_load;
    logic w_is_beq;
    logic w_is_j;
    logic w_is_bad;

    logic w_in_req;
    logic w_waiting;
    logic w_timeout;

    // The ALU zero flag is consumed by the datapath through pc_wr_cond;
    // the sequencer itself never branches on it.
    logic w_zero_unused;
    assign w_zero_unused = zero;

    mc_op_class u_op_class (
        .i_op_code (op_code),
        .o_is_r    (w_is_r),
        .o_is_mem  (w_is_mem),
        .o_is_load (w_is_load),
        .o_is_beq  (w_is_beq),
        .o_is_j    (w_is_j),
        .o_is_bad  (w_is_bad)
    );

    assign w_in_req  = is_mem_state(r_state);
    assign w_waiting = w_in_req && !mem_ready;
    // Timeout wins over a late mem_ready in the same cycle: the request is
    // already being dropped, so the access is treated as abandoned.
    assign w_timeout = (WAIT_MAX != 0) && w_in_req && (r_wait_cnt == WCNT_LIMIT);

    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter: zero outside a stall, so it is always zero on entry to
    // a memory state; saturates when the timeout is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!w_waiting || w_timeout) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WCNT_SAT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Remember lw vs sw at DECODE so op_code need not stay stable afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_is_load <= w_is_load;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_DECODE) && w_is_bad) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Next-state and control-output decode of the registered state
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        i_or_d       = 1'b0;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        pc_wr_cond   = 1'b0;
        pc_src       = PC_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REGB;
        alu_op       = ALU_ADD;
        reg_dst      = 1'b0;
        reg_wr       = 1'b0;
        m2r          = 1'b0;
        instr_done   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end

            ST_FETCH: begin
                // PC + 4 computed while the instruction is read
                mem_req   = !w_timeout;
                alu_src_b = SRCB_FOUR;
                if (w_timeout) begin
                    w_state_next = ST_FETCH;
                end else if (mem_ready) begin
                    ir_wr        = 1'b1;
                    pc_wr        = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Branch target speculatively computed into ALUOut
                alu_src_b = SRCB_IMM_SH2;
                if (w_is_r) begin
                    w_state_next = ST_EXEC_R;
                end else if (w_is_mem) begin
                    w_state_next = ST_ADDR;
                end else if (w_is_beq) begin
                    w_state_next = ST_BRANCH;
                end else if (w_is_j) begin
                    w_state_next = ST_JUMP;
                end else begin
                    instr_done   = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end

            ST_EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_FUNCT;
                w_state_next = ST_R_WB;
            end

            ST_R_WB: begin
                reg_dst      = 1'b1;
                reg_wr       = 1'b1;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                w_state_next = r_is_load ? ST_MEM_RD : ST_MEM_WR;
            end

            ST_MEM_RD: begin
                mem_req = !w_timeout;
                i_or_d  = 1'b1;
                if (w_timeout) begin
                    w_state_next = ST_FETCH;
                end else if (mem_ready) begin
                    w_state_next = ST_LD_WB;
                end
            end

            ST_LD_WB: begin
                m2r          = 1'b1;
                reg_wr       = 1'b1;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_MEM_WR: begin
                mem_req = !w_timeout;
                mem_wr  = !w_timeout;
                i_or_d  = 1'b1;
                if (w_timeout) begin
                    w_state_next = ST_FETCH;
                end else if (mem_ready) begin
                    instr_done   = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end

            ST_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_wr_cond   = 1'b1;
                pc_src       = PC_ALUOUT;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_JUMP: begin
                pc_wr        = 1'b1;
                pc_src       = PC_JUMP;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
